spi_rx_framer: RTL
==================

Name: spi_rx_framer

Overview:
- Downstream consumer of the JTAG-to-SPI loader's flash-side pins. Observes CSB and MISO on the loader's shift clock and deserialises each chip-select frame into MSB-first bytes.
- Buffers the bytes in a small FIFO and presents them on a valid/ready byte stream for on-chip readback/status logic, with per-frame bit count, end-of-frame and overflow reporting.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of frame bit counter; saturating.

Ports:
- DRCK1  in  1  clock; same net and edge (rising) as the loader's capture side.
- rst  in  1  synchronous, active-high reset.
- CSB  in  1  flash chip select from loader, active low.
- MISO  in  1  flash serial data out.
- rx_data  out  8  FIFO head byte, MSB = first captured bit.
- rx_valid  out  1  head byte available.
- rx_ready  in  1  consumer accepts head when rx_valid && rx_ready.
- rx_last  out  1  head byte is the final byte of its frame.
- rx_residue  out  3  valid bits in head byte when rx_last; 0 means all 8.
- frame_bits  out  CNT_W  bits captured in current/most recent frame.
- frame_done  out  1  one-cycle pulse at frame end.
- overflow  out  1  sticky; a byte was dropped on FIFO full.
- crc  out  16  frame CRC (see Optional Feature).

Behaviour:
- Reset: all outputs 0; FIFO empty; state WAIT_HIGH. Clock is one domain; no CDC.
- Capture alignment: cs_q <= !CSB registered each edge. A MISO bit is captured on an edge where cs_q==1, matching the loader's one-cycle RAM write delay. The first bit is taken one cycle after the CSB fall is sampled.
- FSM:
  - WAIT_HIGH -> IDLE when CSB==1. Ignores any frame already in progress at reset or power-up.
  - IDLE -> SHIFT when cs_q rises. On entry: frame_bits=0, bit_cnt=0, crc re-init.
  - SHIFT: per captured bit, shift into sreg (MSB-first), bit_cnt+1 mod 8, frame_bits+1 saturating at all-ones. When bit_cnt wraps, the byte moves to a pending register. A previously pending byte is first pushed with last=0.
  - SHIFT -> FLUSH when cs_q falls.
  - FLUSH (1 cycle):
    - If bit_cnt!=0, push the partial byte left-aligned, zero-padded, with last=1 and residue=bit_cnt. The pending byte, if any, is pushed the cycle before with last=0.
    - Else if a pending byte exists, push it with last=1 and residue=0.
    - Pulse frame_done. Go to IDLE.
  - At most one push per cycle; the FLUSH sequencing guarantees this.
- Empty frame (CSB low under 2 cycles, zero bits): frame_done pulses, frame_bits=0, no push.
- FIFO:
  - Push when full drops the byte and sets overflow. overflow clears only on rst.
  - Push and pop in the same cycle when full: pop frees a slot, push succeeds.
  - Pop when empty is ignored.
  - rx_data/rx_last/rx_residue are stable while rx_valid && !rx_ready.
  - Read latency: byte visible on rx_valid the cycle after its push.
- frame_bits holds its final value until the next SHIFT entry.
- rst mid-frame: FIFO, pending and counters clear immediately, then WAIT_HIGH.
- A new CSB fall during FLUSH is sampled on the next cycle; no bits are lost, because cs_q lags CSB by one cycle.

Optional Feature:
- Macro SPI_RX_CRC_EN.
- Defined: CRC-16/CCITT serial (poly 0x1021, init 0xFFFF, no reflection, no xorout) over every captured bit in capture order. crc holds its final value from the frame_done cycle until the next SHIFT entry.
- Undefined: CRC logic omitted; crc tied to 16'h0000.

Decomposition:
- Package spi_rx_pkg:
  - state encoding (WAIT_HIGH, IDLE, SHIFT, FLUSH);
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF;
  - FIFO entry layout {last, residue[2:0], data[7:0]} = 12 bits.
- One sub-module, spi_rx_fifo: synchronous FIFO_DEPTH x 12 with full/empty, registered head, and simultaneous push/pop.

Test Plan:
- Reset with CSB low and bits toggling, then CSB high, then a 16-bit frame of 0xA55A -> no output for the first frame. Second frame gives 0xA5 (last=0), 0x5A (last=1, residue=0), frame_bits=16, one frame_done pulse.
- 11-bit frame 1010_1100_111 -> 0xAC (last=0), 0xE0 (last=1, residue=3), frame_bits=11.
- CSB low 1 cycle -> frame_done pulses, frame_bits=0, rx_valid stays 0.
- rx_ready=0, 20-byte frame, FIFO_DEPTH=16 -> 16 bytes retained, overflow=1. Drain yields the first 16 bytes in order; overflow stays 1 until rst.
- Full FIFO, rx_ready=1 during a new byte push -> no drop, count unchanged, overflow unchanged.
- SPI_RX_CRC_EN defined, frame "123456789" ASCII (72 bits) -> crc=16'h29B1 at frame_done. Undefined -> crc=0.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// spi_rx_framer shared types: FSM states, CRC constants, FIFO entry.
// CRC step helper is used only when SPI_RX_CRC_EN is defined.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    SHIFT,
    FLUSH
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef struct packed {
    logic       last;
    logic [2:0] residue;
    logic [7:0] data;
  } entry_t;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    logic [15:0] sh;
    sh = {c[14:0], 1'b0};
    return (c[15] ^ b) ? (sh ^ CRC_POLY) : sh;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Byte-entry FIFO with full/empty, gated head and same-cycle push/pop.
// A push into a full FIFO succeeds only if a pop frees a slot that cycle.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   valid,
  output logic   drop
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           do_pop;
  logic           do_push;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Storage array write.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_framer.sv
// SPI frame deserialiser: CSB/MISO on DRCK1 into a byte stream.
// Optional frame CRC-16/CCITT when SPI_RX_CRC_EN is defined.
module spi_rx_framer
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             DRCK1,
  input  logic             rst,
  input  logic             CSB,
  input  logic             MISO,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_last,
  output logic [2:0]       rx_residue,
  output logic [CNT_W-1:0] frame_bits,
  output logic             frame_done,
  output logic             overflow,
  output logic [15:0]      crc
);

  state_t     state;
  state_t     state_nx;
  logic       cs_q;
  logic [7:0] sreg;
  logic [2:0] bit_cnt;
  logic [7:0] pend;
  logic       pend_v;
  logic       cap;
  logic       start;
  logic       push;
  entry_t     push_entry;
  entry_t     head;
  logic       drop;
  logic [7:0] part;
  logic [7:0] cap_byte;

  assign cap        = (state == SHIFT) && cs_q;
  assign start      = (state == IDLE) && cs_q;
  assign part       = sreg << (4'd8 - {1'b0, bit_cnt});
  assign cap_byte   = {sreg[6:0], MISO};
  assign frame_done = (state == FLUSH);

  // Next state and the single push per cycle.
  always_comb begin
    state_nx   = state;
    push       = 1'b0;
    push_entry = '0;
    unique case (state)
      WAIT_HIGH: begin
        if (CSB) state_nx = IDLE;
      end
      IDLE: begin
        if (cs_q) state_nx = SHIFT;
      end
      SHIFT: begin
        if (!cs_q) begin
          state_nx = FLUSH;
          if (bit_cnt != 3'd0 && pend_v) begin
            push       = 1'b1;
            push_entry = '{1'b0, 3'd0, pend};
          end
        end else if (bit_cnt == 3'd7 && pend_v) begin
          push       = 1'b1;
          push_entry = '{1'b0, 3'd0, pend};
        end
      end
      FLUSH: begin
        state_nx = IDLE;
        if (bit_cnt != 3'd0) begin
          push       = 1'b1;
          push_entry = '{1'b1, bit_cnt, part};
        end else if (pend_v) begin
          push       = 1'b1;
          push_entry = '{1'b1, 3'd0, pend};
        end
      end
      default: state_nx = WAIT_HIGH;
    endcase
  end

  // Frame capture state, counters and sticky overflow.
  always_ff @(posedge DRCK1) begin
    if (rst) begin
      state      <= WAIT_HIGH;
      cs_q       <= 1'b0;
      sreg       <= '0;
      bit_cnt    <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      frame_bits <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nx;
      cs_q  <= !CSB;
      if (start) begin
        sreg       <= '0;
        bit_cnt    <= '0;
        pend_v     <= 1'b0;
        frame_bits <= '0;
      end
      if (cap) begin
        sreg    <= cap_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (frame_bits != '1) begin
          frame_bits <= frame_bits + CNT_W'(1);
        end
        if (bit_cnt == 3'd7) begin
          pend   <= cap_byte;
          pend_v <= 1'b1;
        end
      end
      if (state == SHIFT && !cs_q && bit_cnt != 3'd0) begin
        pend_v <= 1'b0;
      end
      if (state == FLUSH) pend_v <= 1'b0;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef SPI_RX_CRC_EN
  logic [15:0] crc_q;

  // Serial CRC over captured bits; holds after frame end.
  always_ff @(posedge DRCK1) begin
    if (rst) begin
      crc_q <= '0;
    end else if (start) begin
      crc_q <= CRC_INIT;
    end else if (cap) begin
      crc_q <= crc_step(crc_q, MISO);
    end
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

  spi_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (DRCK1),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (rx_ready),
    .head      (head),
    .valid     (rx_valid),
    .drop      (drop)
  );

  assign rx_data    = head.data;
  assign rx_last    = head.last;
  assign rx_residue = head.residue;

endmodule
